// File: rtl/spi_sub_pkg.sv
// Shared constants and types for the SPI subordinate FIFO controller.
//   DATA_W        : byte width moved through both FIFOs
//   DEFAULT_DEPTH : default entries per FIFO
//   IDLE_BYTE     : byte presented to the shifter while the TX FIFO is empty
//   level_t       : entry-count type sized for DEFAULT_DEPTH (0..DEFAULT_DEPTH)
package spi_sub_pkg;

    localparam int unsigned DATA_W        = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam logic [DATA_W-1:0] IDLE_BYTE = 8'hFF;

    typedef logic [$clog2(DEFAULT_DEPTH):0] level_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with an explicit level count.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   push, push_data      : write request and data
//   pop                  : read request
//   head                 : raw head entry (meaningful only while empty=0)
//   level, full, empty   : occupancy status
//   push_acc, pop_acc    : request actually accepted this cycle
module spi_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     push_acc,
    output logic                     pop_acc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when a pop frees the slot in the same cycle.
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/spi_sub_fifo_ctrl.sv
// SPI subordinate FIFO controller: a host-to-shifter TX FIFO and a shifter-to-host RX FIFO,
// both first-word-fall-through, with sticky underflow/overflow error flags.
// Ports:
//   pclk, preset                     : clock, synchronous active-high reset
//   tx_wr_en, tx_wdata               : host push into TX
//   load_from_fifo, sub_tx           : shifter pop from TX, TX head (IDLE_BYTE when empty)
//   fifo_load, sub_rx                : shifter push into RX
//   rx_rd_en, rx_rdata               : host pop from RX, RX head (8'h00 when empty)
//   tx_/rx_ full, empty, level       : FIFO status
//   tx_underflow, rx_overflow        : sticky errors, cleared by err_clr (set wins)
module spi_sub_fifo_ctrl
    import spi_sub_pkg::*;
#(
    parameter int unsigned       DEPTH     = spi_sub_pkg::DEFAULT_DEPTH,
    parameter logic [7:0]        IDLE_BYTE = spi_sub_pkg::IDLE_BYTE
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     tx_wr_en,
    input  logic [7:0]               tx_wdata,
    input  logic                     load_from_fifo,
    output logic [7:0]               sub_tx,
    input  logic                     fifo_load,
    input  logic [7:0]               sub_rx,
    input  logic                     rx_rd_en,
    output logic [7:0]               rx_rdata,
    output logic                     tx_full,
    output logic                     tx_empty,
    output logic                     rx_full,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   tx_level,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic                     tx_underflow,
    output logic                     rx_overflow,
    input  logic                     err_clr
);

    logic [DATA_W-1:0] tx_head, rx_head;
    logic tx_push_acc, tx_pop_acc, rx_push_acc, rx_pop_acc;
    logic tx_underflow_q, tx_underflow_d;
    logic rx_overflow_q, rx_overflow_d;

    spi_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_tx_fifo (
        .clk       (pclk),
        .rst       (preset),
        .push      (tx_wr_en),
        .push_data (tx_wdata),
        .pop       (load_from_fifo),
        .head      (tx_head),
        .level     (tx_level),
        .full      (tx_full),
        .empty     (tx_empty),
        .push_acc  (tx_push_acc),
        .pop_acc   (tx_pop_acc)
    );

    spi_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_rx_fifo (
        .clk       (pclk),
        .rst       (preset),
        .push      (fifo_load),
        .push_data (sub_rx),
        .pop       (rx_rd_en),
        .head      (rx_head),
        .level     (rx_level),
        .full      (rx_full),
        .empty     (rx_empty),
        .push_acc  (rx_push_acc),
        .pop_acc   (rx_pop_acc)
    );

    // Host TX drops and host RX empty reads are silent, so these accepts are not needed.
    logic unused_acc;
    assign unused_acc = tx_push_acc ^ rx_pop_acc;

    assign sub_tx   = tx_empty ? IDLE_BYTE : tx_head;
    assign rx_rdata = rx_empty ? 8'h00 : rx_head;

    // A refused shifter request is the error; a same-cycle set beats err_clr.
    always_comb begin
        tx_underflow_d = (load_from_fifo & ~tx_pop_acc) | (tx_underflow_q & ~err_clr);
        rx_overflow_d  = (fifo_load & ~rx_push_acc) | (rx_overflow_q & ~err_clr);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            tx_underflow_q <= 1'b0;
            rx_overflow_q  <= 1'b0;
        end else begin
            tx_underflow_q <= tx_underflow_d;
            rx_overflow_q  <= rx_overflow_d;
        end
    end

    assign tx_underflow = tx_underflow_q;
    assign rx_overflow  = rx_overflow_q;

endmodule

// File: tb/tb_spi_sub_fifo_ctrl.sv
module tb_spi_sub_fifo_ctrl;
    import spi_sub_pkg::*;

    logic       pclk = 1'b0;
    logic       preset, tx_wr_en, load_from_fifo, fifo_load, rx_rd_en, err_clr;
    logic [7:0] tx_wdata, sub_rx, sub_tx, rx_rdata;
    logic       tx_full, tx_empty, rx_full, rx_empty, tx_underflow, rx_overflow;
    level_t     tx_level, rx_level;

    int checks = 0;
    int failures = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic [7:0] exp;

    spi_sub_fifo_ctrl dut (
        .pclk           (pclk),
        .preset         (preset),
        .tx_wr_en       (tx_wr_en),
        .tx_wdata       (tx_wdata),
        .load_from_fifo (load_from_fifo),
        .sub_tx         (sub_tx),
        .fifo_load      (fifo_load),
        .sub_rx         (sub_rx),
        .rx_rd_en       (rx_rd_en),
        .rx_rdata       (rx_rdata),
        .tx_full        (tx_full),
        .tx_empty       (tx_empty),
        .rx_full        (rx_full),
        .rx_empty       (rx_empty),
        .tx_level       (tx_level),
        .rx_level       (rx_level),
        .tx_underflow   (tx_underflow),
        .rx_overflow    (rx_overflow),
        .err_clr        (err_clr)
    );

    always #5 pclk = ~pclk;

    // Apply the currently driven inputs for one edge, then release them.
    task automatic tick();
        @(posedge pclk);
        #1;
        preset = 0; tx_wr_en = 0; load_from_fifo = 0; fifo_load = 0; rx_rd_en = 0; err_clr = 0;
    endtask

    task automatic tx_push(input logic [7:0] d);
        tx_wr_en = 1; tx_wdata = d; txq.push_back(d); tick();
    endtask

    task automatic rx_push(input logic [7:0] d);
        fifo_load = 1; sub_rx = d; rxq.push_back(d); tick();
    endtask

    task automatic test_reset();
        preset = 1; tx_wr_en = 1; fifo_load = 1; load_from_fifo = 1; tick();
        checks++;
        if (sub_tx !== 8'hFF || rx_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_data sub_tx=%h rx_rdata=%h want FF 00", sub_tx, rx_rdata);
        end
        checks++;
        if ({tx_empty, rx_empty, tx_full, rx_full, tx_underflow, rx_overflow} !== 6'b110000
            || tx_level !== 0 || rx_level !== 0) begin
            failures++;
            $display("FAIL reset_status flags=%b tx_level=%0d rx_level=%0d want 110000 0 0",
                     {tx_empty, rx_empty, tx_full, rx_full, tx_underflow, rx_overflow},
                     tx_level, rx_level);
        end
    endtask

    task automatic test_tx_basic();
        tx_push(8'hA5);
        tx_push(8'h3C);
        checks++;
        if (sub_tx !== txq[0] || tx_level !== 2) begin
            failures++;
            $display("FAIL tx_basic_head sub_tx=%h level=%0d want %h 2", sub_tx, tx_level, txq[0]);
        end
        for (int i = 0; i < 2; i++) begin
            exp = txq.pop_front();
            checks++;
            if (sub_tx !== exp) begin
                failures++;
                $display("FAIL tx_basic_pop%0d sub_tx=%h want %h", i, sub_tx, exp);
            end
            load_from_fifo = 1; tick();
        end
        checks++;
        if (sub_tx !== 8'hFF || tx_empty !== 1'b1) begin
            failures++;
            $display("FAIL tx_basic_empty sub_tx=%h empty=%b want FF 1", sub_tx, tx_empty);
        end
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 8; i++) tx_push(8'(i));
        tx_wr_en = 1; tx_wdata = 8'hFF; tick();  // dropped, not modelled in txq
        checks++;
        if (tx_full !== 1'b1 || tx_level !== 8) begin
            failures++;
            $display("FAIL tx_full_status full=%b level=%0d want 1 8", tx_full, tx_level);
        end
        for (int i = 0; i < 8; i++) begin
            exp = txq.pop_front();
            checks++;
            if (sub_tx !== exp) begin
                failures++;
                $display("FAIL tx_full_order%0d sub_tx=%h want %h", i, sub_tx, exp);
            end
            load_from_fifo = 1; tick();
        end
        checks++;
        if (tx_empty !== 1'b1 || sub_tx !== 8'hFF || tx_underflow !== 1'b0) begin
            failures++;
            $display("FAIL tx_full_drain empty=%b sub_tx=%h uf=%b want 1 FF 0",
                     tx_empty, sub_tx, tx_underflow);
        end
    endtask

    task automatic test_underflow();
        load_from_fifo = 1; tick();
        checks++;
        if (tx_underflow !== 1'b1 || sub_tx !== 8'hFF || tx_level !== 0) begin
            failures++;
            $display("FAIL underflow_set uf=%b sub_tx=%h level=%0d want 1 FF 0",
                     tx_underflow, sub_tx, tx_level);
        end
        err_clr = 1; tick();
        checks++;
        if (tx_underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clr uf=%b want 0", tx_underflow);
        end
        err_clr = 1; load_from_fifo = 1; tick();
        checks++;
        if (tx_underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set_wins uf=%b want 1", tx_underflow);
        end
        err_clr = 1; tick();
    endtask

    task automatic test_rx_overflow();
        rx_rd_en = 1; tick();  // pop on empty: no effect
        checks++;
        if (rx_empty !== 1'b1 || rx_level !== 0 || rx_rdata !== 8'h00) begin
            failures++;
            $display("FAIL rx_empty_read empty=%b level=%0d data=%h want 1 0 00",
                     rx_empty, rx_level, rx_rdata);
        end
        for (int i = 0; i < 8; i++) rx_push(8'h10 + 8'(i));
        fifo_load = 1; sub_rx = 8'h99; tick();  // dropped
        checks++;
        if (rx_overflow !== 1'b1 || rx_full !== 1'b1 || rx_rdata !== rxq[0] || rx_level !== 8) begin
            failures++;
            $display("FAIL rx_overflow_set ov=%b full=%b head=%h level=%0d want 1 1 %h 8",
                     rx_overflow, rx_full, rx_rdata, rx_level, rxq[0]);
        end
        err_clr = 1; tick();
        exp = rxq.pop_front();
        checks++;
        if (rx_rdata !== exp) begin
            failures++;
            $display("FAIL rx_full_pushpop_head data=%h want %h", rx_rdata, exp);
        end
        fifo_load = 1; sub_rx = 8'h99; rx_rd_en = 1; rxq.push_back(8'h99); tick();
        checks++;
        if (rx_level !== 8 || rx_overflow !== 1'b0 || rx_rdata !== rxq[0]) begin
            failures++;
            $display("FAIL rx_full_pushpop level=%0d ov=%b head=%h want 8 0 %h",
                     rx_level, rx_overflow, rx_rdata, rxq[0]);
        end
        for (int i = 0; i < 8; i++) begin
            exp = rxq.pop_front();
            checks++;
            if (rx_rdata !== exp) begin
                failures++;
                $display("FAIL rx_drain%0d data=%h want %h", i, rx_rdata, exp);
            end
            rx_rd_en = 1; tick();
        end
        checks++;
        if (rx_empty !== 1'b1 || rx_rdata !== 8'h00) begin
            failures++;
            $display("FAIL rx_drain_empty empty=%b data=%h want 1 00", rx_empty, rx_rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) tx_push(8'($urandom));
        for (int i = 0; i < 20; i++) begin
            exp = txq.pop_front();
            checks++;
            if (sub_tx !== exp) begin
                failures++;
                $display("FAIL wrap_data%0d sub_tx=%h want %h", i, sub_tx, exp);
            end
            tx_wdata = 8'($urandom);
            txq.push_back(tx_wdata);
            tx_wr_en = 1; load_from_fifo = 1; tick();
            checks++;
            if (tx_level !== 3) begin
                failures++;
                $display("FAIL wrap_level%0d level=%0d want 3", i, tx_level);
            end
        end
        while (txq.size() > 0) begin
            exp = txq.pop_front();
            checks++;
            if (sub_tx !== exp) begin
                failures++;
                $display("FAIL wrap_drain sub_tx=%h want %h", sub_tx, exp);
            end
            load_from_fifo = 1; tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) tx_push(8'h50 + 8'(i));
        for (int i = 0; i < 8; i++) rx_push(8'h60 + 8'(i));
        fifo_load = 1; sub_rx = 8'hEE; tick();
        checks++;
        if (tx_level !== 5 || rx_overflow !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre tx_level=%0d ov=%b want 5 1", tx_level, rx_overflow);
        end
        preset = 1; tx_wr_en = 1; tx_wdata = 8'h77; fifo_load = 1; rx_rd_en = 1; tick();
        txq.delete(); rxq.delete();
        checks++;
        if (sub_tx !== 8'hFF || rx_rdata !== 8'h00 || tx_level !== 0 || rx_level !== 0 ||
            {tx_empty, rx_empty, tx_full, rx_full, tx_underflow, rx_overflow} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_mid sub_tx=%h rx=%h lv=%0d/%0d flags=%b want FF 00 0/0 110000",
                     sub_tx, rx_rdata, tx_level, rx_level,
                     {tx_empty, rx_empty, tx_full, rx_full, tx_underflow, rx_overflow});
        end
    endtask

    initial begin
        preset = 0; tx_wr_en = 0; load_from_fifo = 0; fifo_load = 0; rx_rd_en = 0; err_clr = 0;
        tx_wdata = 0; sub_rx = 0;
        test_reset();
        test_tx_basic();
        test_tx_full();
        test_underflow();
        test_rx_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_sub_fifo_ctrl.md
SPI_SUB_FIFO_CTRL -- requirements
Module: spi_sub_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning entries per FIFO (power of two, >=2).
REQ-002 The block SHALL have parameter IDLE_BYTE, default 8'hFF, meaning the byte driven on sub_tx when the TX FIFO is empty.
REQ-003 pclk  input  1  sole clock; all logic on its rising edge.
REQ-004 preset  input  1  synchronous, active-high reset.
REQ-005 tx_wr_en  input  1  host push request into the TX FIFO.
REQ-006 tx_wdata  input  8  host byte to transmit.
REQ-007 load_from_fifo  input  1  subordinate-side one-cycle pop request on the TX FIFO.
REQ-008 sub_tx  output  8  TX head byte presented to the subordinate shifter.
REQ-009 fifo_load  input  1  subordinate-side one-cycle push request on the RX FIFO.
REQ-010 sub_rx  input  8  byte received by the subordinate.
REQ-011 rx_rd_en  input  1  host pop request on the RX FIFO.
REQ-012 rx_rdata  output  8  RX head byte.
REQ-013 tx_full, tx_empty, rx_full, rx_empty  output  1 each  FIFO status.
REQ-014 tx_level, rx_level  output  $clog2(DEPTH)+1  entry counts, 0..DEPTH.
REQ-015 tx_underflow, rx_overflow  output  1 each  sticky error flags.
REQ-016 err_clr  input  1  clears both sticky flags.

Function
REQ-017 Both FIFOs SHALL be first-word-fall-through: the head byte is visible on sub_tx/rx_rdata with no read latency.
REQ-018 sub_tx SHALL equal the TX head when tx_empty=0 and IDLE_BYTE when tx_empty=1.
REQ-019 rx_rdata SHALL equal the RX head when rx_empty=0 and 8'h00 when rx_empty=1.
REQ-020 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop is accepted in the same cycle.
REQ-021 A pop SHALL be accepted only when the FIFO is not empty; a push in the same cycle does not make a pop on an empty FIFO valid.
REQ-022 Accepted pushes and pops SHALL update level, pointers and flags on the next rising edge; simultaneous push+pop SHALL leave the level unchanged.
REQ-023 Pointers SHALL wrap from DEPTH-1 to 0; full is level==DEPTH and empty is level==0, with no lost slot.
REQ-024 A rejected host tx_wr_en while full SHALL drop the byte silently; the host is responsible for checking tx_full.
REQ-025 load_from_fifo while tx_empty=1 SHALL leave the FIFO unchanged and set tx_underflow on the next edge.
REQ-026 fifo_load while rx_full=1 with no same-cycle rx_rd_en SHALL drop sub_rx, keep the stored data, and set rx_overflow.
REQ-027 A rejected rx_rd_en while empty SHALL have no effect.
REQ-028 err_clr SHALL clear both sticky flags; if a set condition coincides with err_clr, the flag SHALL end set (set wins).

Reset
REQ-029 preset=1 on a pclk edge SHALL zero pointers and levels; tx_empty=rx_empty=1, tx_full=rx_full=0, flags=0, sub_tx=IDLE_BYTE, rx_rdata=8'h00.
REQ-030 Reset SHALL take priority over all concurrent requests.
REQ-031 Reset mid-transfer SHALL discard stored data; storage contents need not be cleared.

Structure
REQ-032 The package spi_sub_pkg SHALL hold DATA_W=8, the DEFAULT_DEPTH constant, the IDLE_BYTE constant, and a level typedef.
REQ-033 One generic sub-module, spi_sync_fifo (FWFT, level count, push/pop accept outputs), SHALL be instantiated twice.
REQ-034 Error detection and the sticky flags SHALL reside in the top module.

Verification
REQ-035 After reset: push 8'hA5 and 8'h3C via tx_wr_en -> sub_tx=8'hA5 on the next cycle, tx_level=2; after a load_from_fifo pulse, sub_tx=8'h3C.
REQ-036 Push 8 bytes 8'h00..8'h07 then a 9th 8'hFF -> tx_full=1, tx_level=8, the 9th byte is dropped; 8 pops return 8'h00..8'h07 in order and tx_empty=1.
REQ-037 Pulse load_from_fifo on an empty TX FIFO -> sub_tx stays 8'hFF and tx_underflow=1; pulse err_clr -> tx_underflow=0.
REQ-038 Fill RX with 8 bytes, then fifo_load with 8'h99 -> rx_overflow=1 and the head is still the first byte; repeat with a same-cycle rx_rd_en -> 8'h99 is accepted and rx_level stays 8.
REQ-039 Perform 20 pushes and pops at level 3 to cross the pointer wrap -> data order is preserved and the level is constant.
REQ-040 Assert preset while tx_level=5 and rx_overflow=1 -> all reset values from REQ-029 hold on the next cycle.
